// File: rtl/seven_seg_scan.sv
// seven_seg_scan
//   Time-multiplexed driver for an NDIG-digit common-anode seven-segment
//   display. A packed hex value (plus per-digit decimal points) is captured
//   into a shadow register on a load strobe; the scanner lights one digit
//   per prescaled slot and drives active-low segments and anodes. Optional
//   leading-zero blanking and per-digit blink are applied at each slot.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   load       capture value/dp_in into the shadow this edge
//   value      packed hex digits, digit k = value[4k+3:4k], digit 0 rightmost
//   dp_in      decimal point request per digit (1 = lit)
//   blank_lz   1 = blank leading zero digits (sampled at each slot update)
//   blink_en   1 = digit blinks
//   seg        segments {a,b,c,d,e,f,g}, seg[6]=a, active-low
//   dp         decimal point, active-low
//   an         digit enables, active-low, one-hot-low while scanning
//   digit_idx  index of the digit currently driven
module seven_seg_scan #(
  parameter int NDIG        = 4,
  parameter int PRESCALE    = 50000,
  parameter int BLINK_SCANS = 64,
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1,
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              blank_lz,
  input  logic [NDIG-1:0]   blink_en,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic [IW-1:0]     digit_idx
);

  // Hex to active-low abcdefg.
  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // State
  logic [4*NDIG-1:0] val_q, val_d;
  logic [NDIG-1:0]   sdp_q, sdp_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [BW-1:0]     frm_q, frm_d;
  logic              phase_q, phase_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;

  // Helpers
  logic              tick;
  logic [IW-1:0]     idx_n;
  logic [NDIG-1:0]   lz_mask;
  logic [3:0]        nib;
  logic              blank, blk;

  assign tick  = (presc_q == PW'(PRESCALE - 1));
  assign idx_n = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
  assign nib   = val_q[{idx_n, 2'b00} +: 4];

  // lz_mask[k] = 1 when digit k and every digit above it are zero.
  // Digit 0 is excluded so an all-zero value still shows a single 0.
  always_comb begin
    logic z;
    z       = 1'b1;
    lz_mask = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      z          = z && (val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = z && (k > 0);
    end
  end

  // Blink uses the phase in force before this edge, so the phase toggle
  // at a frame boundary takes effect from the following frame.
  assign blank = blank_lz && lz_mask[idx_n];
  assign blk   = phase_q && blink_en[idx_n];

  always_comb begin
    val_d   = val_q;
    sdp_d   = sdp_q;
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    frm_d   = frm_q;
    phase_d = phase_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    an_d    = an_q;

    // The slot outputs below read val_q/sdp_q, so a load on the same edge
    // only becomes visible at the next slot.
    if (load) begin
      val_d = value;
      sdp_d = dp_in;
    end

    if (tick) begin
      presc_d = '0;
      idx_d   = idx_n;
      an_d    = ~(NDIG'(1) << idx_n);
      seg_d   = (blank || blk) ? 7'b1111111 : hex2seg(nib);
      dp_d    = blk ? 1'b1 : ~sdp_q[idx_n];
      if (idx_n == '0) begin
        if (frm_q == BW'(BLINK_SCANS - 1)) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d = frm_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q   <= '0;
      sdp_q   <= '0;
      presc_q <= '0;
      idx_q   <= IW'(NDIG - 1);
      frm_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= 7'b1111111;
      dp_q    <= 1'b1;
      an_q    <= '1;
    end else begin
      val_q   <= val_d;
      sdp_q   <= sdp_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NDIG=4, PRESCALE=4, BLINK_SCANS=2.
module tb_seven_seg_scan;
  localparam int NDIG = 4;
  localparam int PS   = 4;
  localparam int BS   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int n_chk = 0;
  int n_fail = 0;

  seven_seg_scan #(.NDIG(NDIG), .PRESCALE(PS), .BLINK_SCANS(BS)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dp(dp), .an(an),
    .digit_idx(digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp);
    chk({tag, "_an"}, {28'b0, an}, {28'b0, ean});
    chk({tag, "_seg"}, {25'b0, seg}, {25'b0, eseg});
    chk({tag, "_dp"}, {31'b0, dp}, {31'b0, edp});
  endtask

  // Advance n edges, then settle 1 ns past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance until the slot update that makes digit k the lit digit.
  task automatic wait_slot(input logic [1:0] k);
    logic       found;
    logic [1:0] prev;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = digit_idx;
      step(1);
      if (digit_idx == k && prev != k) found = 1'b1;
    end
    chk("slot_wait", {31'b0, found}, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v;
    dp_in = d;
    load  = 1'b1;
    step(1);
    load  = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk_out("rst", 4'hF, 7'b1111111, 1'b1);
    chk("rst_idx", {30'b0, digit_idx}, 32'd3);

    // Release with a one-cycle load of 1234; first slot after PRESCALE edges
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_load(16'h1234, 4'h0);
    chk("e1_an", {28'b0, an}, 32'hF);
    step(2);
    chk("e3_an", {28'b0, an}, 32'hF);
    step(1);
    chk_out("e4", 4'b1110, 7'b1001100, 1'b1);
    step(4);
    chk_out("e8", 4'b1101, 7'b0000110, 1'b1);
    step(4);
    chk_out("e12", 4'b1011, 7'b0010010, 1'b1);
    step(4);
    chk_out("e16", 4'b0111, 7'b1001111, 1'b1);
    step(4);
    chk_out("e20", 4'b1110, 7'b1001100, 1'b1);

    // Leading-zero blanking on 0A05
    blank_lz = 1'b1;
    do_load(16'h0A05, 4'h0);
    wait_slot(0); chk_out("lz_d0", 4'b1110, 7'b0100100, 1'b1);
    wait_slot(1); chk_out("lz_d1", 4'b1101, 7'b0000001, 1'b1);
    wait_slot(2); chk_out("lz_d2", 4'b1011, 7'b0001000, 1'b1);
    wait_slot(3); chk_out("lz_d3", 4'b0111, 7'b1111111, 1'b1);
    blank_lz = 1'b0;
    wait_slot(3); chk_out("nolz_d3", 4'b0111, 7'b0000001, 1'b1);

    // Zero value with blanking: single 0, blanked digit still shows dp
    blank_lz = 1'b1;
    do_load(16'h0000, 4'b0100);
    wait_slot(0); chk_out("z_d0", 4'b1110, 7'b0000001, 1'b1);
    wait_slot(1); chk_out("z_d1", 4'b1101, 7'b1111111, 1'b1);
    wait_slot(2); chk_out("z_d2", 4'b1011, 7'b1111111, 1'b0);
    wait_slot(3); chk_out("z_d3", 4'b0111, 7'b1111111, 1'b1);

    // Load while digit1 lit does not disturb it
    blank_lz = 1'b0;
    do_load(16'h1234, 4'h0);
    wait_slot(1); chk_out("ld_pre", 4'b1101, 7'b0000110, 1'b1);
    do_load(16'hFFFF, 4'h0);
    chk_out("ld_same", 4'b1101, 7'b0000110, 1'b1);
    step(2);
    chk_out("ld_hold", 4'b1101, 7'b0000110, 1'b1);
    wait_slot(2); chk_out("ld_next", 4'b1011, 7'b0111000, 1'b1);

    // Asynchronous reset mid-slot while digit2 lit
    wait_slot(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("arst", 4'hF, 7'b1111111, 1'b1);
    chk("arst_idx", {30'b0, digit_idx}, 32'd3);
    #1;
    rst_n = 1'b1;
    step(3);
    chk("arst_e3_an", {28'b0, an}, 32'hF);
    step(1);
    chk_out("arst_d0", 4'b1110, 7'b0000001, 1'b1);

    // Blink: digit0 lit two frames, dark two frames (anode still low)
    rst_n = 1'b0;
    #2;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    blink_en = 4'b0001;
    do_load(16'h8888, 4'b0001);
    for (int f = 0; f < 6; f++) begin
      logic lit;
      lit = ((f / 2) % 2) == 0;
      wait_slot(0);
      chk_out($sformatf("blk_f%0d_d0", f), 4'b1110,
              lit ? 7'b0000000 : 7'b1111111, lit ? 1'b0 : 1'b1);
      for (int d = 1; d < 4; d++) begin
        logic [3:0] one;
        logic [3:0] ea;
        one = 4'b0001;
        ea  = ~(one << d);
        wait_slot(d[1:0]);
        chk_out($sformatf("blk_f%0d_d%0d", f, d), ea, 7'b0000000, 1'b1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
